spi_slave_fsm: RTL and testbench

SPI slave front-end that deserialises MOSI into 10-bit command words for the downstream 256×8 memory stage and serialises read data back onto MISO. Each complete word is presented as a one-cycle `rx_valid` pulse with `rx_data[9:8]` as opcode and `rx_data[7:0]` as address or data. On a read-data command, the block waits for the memory's `tx_valid`, then shifts `tx_data` out MSB first. It is the first stage of the SPI slave subsystem, directly upstream of the memory.

---
 rtl/spi_slave_pkg.sv | 37 +++
 rtl/spi_slave_if.sv | 23 ++
 rtl/spi_miso_serializer.sv | 42 ++++
 rtl/spi_slave_fsm.sv | 105 ++++++++++
 tb/tb_spi_slave_fsm.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front-end.
package spi_slave_pkg;

    localparam int unsigned WORD_W    = 10;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = $clog2(WORD_W + 1);
    localparam int unsigned SER_CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [WORD_W-3:0] payload;
    } cmd_word_t;

    // Opcode legality for the shift state that collected the word.
    function automatic logic opcode_ok(input state_e st, input logic [1:0] op);
        case (st)
            WRITE:     opcode_ok = (op == OP_WR_ADDR) || (op == OP_WR_DATA);
            READ_ADD:  opcode_ok = (op == OP_RD_ADDR);
            READ_DATA: opcode_ok = (op == OP_RD_DATA);
            default:   opcode_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Serial pins plus the command/read-data handshake toward the memory stage.
interface spi_slave_if;
    import spi_slave_pkg::*;

    logic              ss_n;
    logic              mosi;
    logic              miso;
    cmd_word_t         rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              cmd_err;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid, cmd_err
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid, cmd_err
    );
endinterface

// File: rtl/spi_miso_serializer.sv
// Loads one read-data byte per frame and shifts it onto MISO, MSB first.
module spi_miso_serializer
    import spi_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              load_req,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso
);
    logic [DATA_W-1:0]    sh;
    logic [SER_CNT_W-1:0] cnt;
    logic                 loaded;
    logic                 done;

    // loaded blocks reloads while tx_valid stays high; done parks miso at 0.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            sh     <= '0;
            cnt    <= '0;
            loaded <= 1'b0;
            done   <= 1'b0;
            miso   <= 1'b0;
        end else if (load_req && !loaded) begin
            sh     <= {tx_data[DATA_W-2:0], 1'b0};
            cnt    <= SER_CNT_W'(1);
            loaded <= 1'b1;
            miso   <= tx_data[DATA_W-1];
        end else if (loaded && !done) begin
            if (cnt == SER_CNT_W'(DATA_W)) begin
                miso <= 1'b0;
                done <= 1'b1;
            end else begin
                miso <= sh[DATA_W-1];
                sh   <= {sh[DATA_W-2:0], 1'b0};
                cnt  <= cnt + SER_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave: deserialises 10-bit command words and returns read data on MISO.
// Optional opcode-bit-8 checking is enabled by defining SPI_SLAVE_CMD_CHECK_EN.
module spi_slave_fsm
    import spi_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
    state_e               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [WORD_W-2:0]    shreg;
    logic                 rd_addr_flag;
    logic                 rd_armed;
    cmd_word_t            rx_data_q;
    logic                 rx_valid_q;
    logic                 ser_miso;
    cmd_word_t            word_c;
    logic                 last_bit_c;
    logic                 word_ok_c;
`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic                 cmd_err_q;
`endif

    assign word_c     = cmd_word_t'({shreg, bus.mosi});
    assign last_bit_c = (bit_cnt == BIT_CNT_W'(WORD_W - 1));

`ifdef SPI_SLAVE_CMD_CHECK_EN
    assign word_ok_c   = opcode_ok(state, word_c.op);
    assign bus.cmd_err = cmd_err_q;
`else
    assign word_ok_c   = 1'b1;
    assign bus.cmd_err = 1'b0;
`endif

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.miso     = ser_miso;

    // Frame sequencing, word assembly and read-address bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            rd_addr_flag <= 1'b0;
            rd_armed     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
`ifdef SPI_SLAVE_CMD_CHECK_EN
            cmd_err_q    <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_CMD_CHECK_EN
            cmd_err_q  <= 1'b0;
`endif
            if (bus.ss_n) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                rd_armed <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= CHK_CMD;
                    CHK_CMD: begin
                        shreg   <= {shreg[WORD_W-3:0], bus.mosi};
                        bit_cnt <= BIT_CNT_W'(1);
                        if (!bus.mosi)        state <= WRITE;
                        else if (rd_addr_flag) state <= READ_DATA;
                        else                  state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt != BIT_CNT_W'(WORD_W)) begin
                            shreg   <= {shreg[WORD_W-3:0], bus.mosi};
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                        if (last_bit_c && word_ok_c) begin
                            rx_data_q  <= word_c;
                            rx_valid_q <= 1'b1;
                            if (state == READ_ADD) rd_addr_flag <= 1'b1;
                            if (state == READ_DATA) begin
                                rd_addr_flag <= 1'b0;
                                rd_armed     <= 1'b1;
                            end
                        end
`ifdef SPI_SLAVE_CMD_CHECK_EN
                        if (last_bit_c && !word_ok_c) cmd_err_q <= 1'b1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    spi_miso_serializer u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (bus.ss_n),
        .load_req (rd_armed && bus.tx_valid),
        .tx_data  (bus.tx_data),
        .miso     (ser_miso)
    );

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed scoreboard bench for spi_slave_fsm with a small memory responder.
module tb_spi_slave_fsm;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    spi_slave_if bus();

    spi_slave_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned       vectors     = 0;
    int unsigned       miscompares = 0;
    int unsigned       rx_cnt      = 0;
    int unsigned       err_cnt     = 0;
    int unsigned       exp_rx      = 0;
    logic [WORD_W-1:0] rx_q[$];
    logic              miso_q[$];
    logic [DATA_W-1:0] mem_byte    = '0;
    logic              mem_pend    = 1'b0;
    logic              prev_rv     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rx(input logic [WORD_W-1:0] w);
        rx_q.push_back(w);
        exp_rx++;
    endtask

    // Present the first n bits of w, MSB first, with ss_n low.
    task automatic send_bits(input logic [WORD_W-1:0] w, input int n);
        @(negedge clk);
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.mosi = w[WORD_W-1-i];
        end
    endtask

    task automatic end_frame(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("miso_idle", bus.miso, 1'b0);
        end
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        @(negedge clk);
        check("state_idle", dut.state, IDLE);
        miso_q.delete();
    endtask

    task automatic read_data(input logic [WORD_W-1:0] w, input logic [DATA_W-1:0] d);
        logic exp_bit;
        mem_byte = d;
        expect_rx(w);
        send_bits(w, WORD_W);
        repeat (2) begin
            @(negedge clk);
            check("miso_lead", bus.miso, 1'b0);
        end
        for (int i = 0; i < DATA_W; i++) begin
            @(negedge clk);
            exp_bit = (miso_q.size() != 0) ? miso_q.pop_front() : 1'bx;
            check("miso_bit", bus.miso, exp_bit);
        end
        check("flag_after_rd_data", dut.rd_addr_flag, 1'b0);
        end_frame(4);
    endtask

    // Scoreboard: every rx_valid pulse pops one expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.rx_valid === 1'b1) begin
                rx_cnt++;
                check("rx_back_to_back", prev_rv, 1'b0);
                if (rx_q.size() == 0) check("rx_spurious", bus.rx_valid, 1'b0);
                else                  check("rx_data", bus.rx_data, rx_q.pop_front());
            end
            if (rst_n === 1'b1 && bus.cmd_err === 1'b1) err_cnt++;
            prev_rv = bus.rx_valid;
        end
    end

    // Memory responder: raises tx_valid one cycle after a read-data word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || bus.ss_n !== 1'b0) begin
                bus.tx_valid = 1'b0;
                bus.tx_data  = '0;
                mem_pend     = 1'b0;
            end else begin
                if (mem_pend && !bus.tx_valid) begin
                    bus.tx_valid = 1'b1;
                    bus.tx_data  = mem_byte;
                    for (int i = DATA_W - 1; i >= 0; i--) miso_q.push_back(mem_byte[i]);
                    mem_pend = 1'b0;
                end
                if (bus.rx_valid === 1'b1 && bus.rx_data.op == OP_RD_DATA) mem_pend = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned rx_before;
        int unsigned err_before;
        logic        exp_bit;

        rst_n    = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", bus.miso, 1'b0);
        check("rst_rx_data", bus.rx_data, '0);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_cmd_err", bus.cmd_err, 1'b0);
        check("rst_flag", dut.rd_addr_flag, 1'b0);
        check("rst_state", dut.state, IDLE);
        rst_n = 1'b1;

        expect_rx({OP_WR_ADDR, 8'h12});
        send_bits({OP_WR_ADDR, 8'h12}, WORD_W);
        end_frame(3);
        check("flag_after_wr_addr", dut.rd_addr_flag, 1'b0);

        expect_rx({OP_WR_DATA, 8'hA5});
        send_bits({OP_WR_DATA, 8'hA5}, WORD_W);
        end_frame(3);
        check("flag_after_wr_data", dut.rd_addr_flag, 1'b0);

        expect_rx({OP_RD_ADDR, 8'h12});
        send_bits({OP_RD_ADDR, 8'h12}, WORD_W);
        end_frame(3);
        check("flag_after_rd_addr", dut.rd_addr_flag, 1'b1);

        read_data({OP_RD_DATA, 8'h3C}, 8'hA5);

        rx_before = rx_cnt;
        send_bits({OP_WR_DATA, 8'h55}, 6);
        @(negedge clk);
        bus.ss_n = 1'b1;
        @(negedge clk);
        check("abort_state", dut.state, IDLE);
        check("abort_cnt", dut.bit_cnt, '0);
        repeat (2) @(negedge clk);
        check("abort_no_rx", rx_cnt, rx_before);
        expect_rx({OP_WR_ADDR, 8'h03});
        send_bits({OP_WR_ADDR, 8'h03}, WORD_W);
        end_frame(3);

        expect_rx({OP_RD_ADDR, 8'hFF});
        send_bits({OP_RD_ADDR, 8'hFF}, WORD_W);
        end_frame(3);
        mem_byte = 8'h3C;
        expect_rx({OP_RD_DATA, 8'h00});
        send_bits({OP_RD_DATA, 8'h00}, WORD_W);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_bit = (miso_q.size() != 0) ? miso_q.pop_front() : 1'bx;
            check("miso_pre_reset", bus.miso, exp_bit);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_miso", bus.miso, 1'b0);
        check("midrst_flag", dut.rd_addr_flag, 1'b0);
        check("midrst_state", dut.state, IDLE);
        check("midrst_rx_data", bus.rx_data, '0);
        bus.ss_n = 1'b1;
        rst_n    = 1'b1;
        miso_q.delete();
        @(negedge clk);

`ifdef SPI_SLAVE_CMD_CHECK_EN
        err_before = err_cnt;
        send_bits({OP_RD_DATA, 8'h00}, WORD_W);
        end_frame(12);
        check("cmd_err_pulses", err_cnt, err_before + 1);
        check("flag_after_bad_cmd", dut.rd_addr_flag, 1'b0);
        expect_rx({OP_RD_ADDR, 8'h40});
        send_bits({OP_RD_ADDR, 8'h40}, WORD_W);
        end_frame(3);
`else
        err_before = err_cnt;
        expect_rx({OP_RD_DATA, 8'h00});
        send_bits({OP_RD_DATA, 8'h00}, WORD_W);
        end_frame(12);
        check("flag_after_post_reset_read", dut.rd_addr_flag, 1'b1);
        check("cmd_err_tied_low", err_cnt, err_before);
`endif
        check("flag_before_final_read", dut.rd_addr_flag, 1'b1);

        read_data({OP_RD_DATA, 8'hC3}, 8'h81);

        repeat (2) @(negedge clk);
        check("rx_queue_drained", rx_q.size(), 0);
        check("rx_pulse_count", rx_cnt, exp_rx);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
